bcd2_display_scan: RTL and testbench

Two-digit multiplexed seven-segment scanner that consumes the `bcd1`/`bcd2` digit pair produced by the 2-digit BCD counter and drives a common-segment, two-digit display.

- Snapshots both digits once per scan frame so a 09→10 rollover never tears a frame.
- Time-multiplexes the digits with inter-digit blanking.
- Supports optional leading-zero suppression.
- Flags any non-BCD input code.

---
 rtl/bcd_disp_pkg.sv | 26 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/bcd2_display_scan.sv | 130 +++++++++++++
 tb/tb_bcd2_display_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit seven-segment scanner: state encoding
// and segment patterns (bit 0 = segment a ... bit 6 = segment g).
package bcd_disp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW0 = 3'd1,
        GAP0  = 3'd2,
        SHOW1 = 3'd3,
        GAP1  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; non-BCD codes show "E".
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd2_display_scan.sv
// Two-digit multiplexed seven-segment scanner with per-frame digit snapshot,
// inter-digit blanking, leading-zero suppression and a sticky bad-code flag.
module bcd2_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic       lzb,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_tick,
    output logic       err
);

    localparam int MAXC         = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int DW           = $clog2(MAXC + 1);
    localparam int BLANK_LAST_I = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic [DW-1:0] SHOW_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_LAST_I);
    localparam logic          HAS_GAP    = (BLANK_CYC > 0);

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   dwell;
    logic            snap_take;
    logic [3:0]      snap1;
    logic [3:0]      snap2;
    logic            snap_lzb;
    logic [3:0]      dec_in;
    logic [6:0]      dec_out;

    // Next-state logic; snap_take marks the cycle whose closing edge enters SHOW0.
    always_comb begin
        state_next = state;
        snap_take  = 1'b0;
        case (state)
            IDLE: begin
                state_next = SHOW0;
                snap_take  = 1'b1;
            end
            SHOW0: begin
                if (dwell == SHOW_LAST) begin
                    state_next = HAS_GAP ? GAP0 : SHOW1;
                end
            end
            GAP0: begin
                if (dwell == BLANK_LAST) begin
                    state_next = SHOW1;
                end
            end
            SHOW1: begin
                if (dwell == SHOW_LAST) begin
                    state_next = HAS_GAP ? GAP1 : SHOW0;
                    snap_take  = ~HAS_GAP;
                end
            end
            GAP1: begin
                if (dwell == BLANK_LAST) begin
                    state_next = SHOW0;
                    snap_take  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            dwell    <= '0;
            snap1    <= 4'd0;
            snap2    <= 4'd0;
            snap_lzb <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                dwell <= '0;
            end else begin
                dwell <= dwell + DW'(1);
            end
            if (snap_take) begin
                snap1    <= bcd1;
                snap2    <= bcd2;
                snap_lzb <= lzb;
                if ((bcd1 > 4'd9) || (bcd2 > 4'd9)) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign dec_in = (state == SHOW1) ? snap2 : snap1;

    bcd_to_seg7 u_dec (
        .bcd (dec_in),
        .seg (dec_out)
    );

    // Outputs depend only on registered state and snapshot.
    always_comb begin
        seg        = SEG_OFF;
        dig_en     = 2'b00;
        frame_tick = snap_take && (state != IDLE);
        case (state)
            SHOW0: begin
                seg    = dec_out;
                dig_en = 2'b01;
            end
            SHOW1: begin
                if (!(snap_lzb && (snap2 == 4'd0))) begin
                    seg    = dec_out;
                    dig_en = 2'b10;
                end
            end
            default: begin
                seg    = SEG_OFF;
                dig_en = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd2_display_scan.sv
// Directed bench for bcd2_display_scan at default parameters (10-cycle frame).
module tb_bcd2_display_scan;

    logic       clk;
    logic       rst;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic       lzb;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_tick;
    logic       err;

    int n_vec;
    int n_err;

    bcd2_display_scan #(
        .SCAN_DIV  (4),
        .BLANK_CYC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .lzb        (lzb),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, {1'b0, seg}, 8'h00);
        check({tag, "_dig"}, {6'd0, dig_en}, 8'h00);
        check({tag, "_ft"}, {7'd0, frame_tick}, 8'h00);
        check({tag, "_err"}, {7'd0, err}, 8'h00);
    endtask

    // One frame: cycles 0-3 units lit, 4 blank, 5-8 tens lit (or blanked), 9 blank + tick.
    // chg_at changes the digit inputs after that cycle's check; rst_at asserts
    // reset during that cycle (with a bad units code present) and ends the frame.
    task automatic run_frame(input string tag, input logic [6:0] u_seg, input logic [6:0] t_seg,
                             input logic t_lit, input logic exp_err, input int chg_at,
                             input logic [3:0] nb2, input logic [3:0] nb1, input int rst_at);
        logic [6:0] e_seg;
        logic [1:0] e_dig;
        logic       e_ft;
        for (int i = 0; i < 10; i++) begin
            step();
            e_seg = 7'h00;
            e_dig = 2'b00;
            e_ft  = (i == 9);
            if (i < 4) begin
                e_seg = u_seg;
                e_dig = 2'b01;
            end else if (i >= 5 && i <= 8 && t_lit) begin
                e_seg = t_seg;
                e_dig = 2'b10;
            end
            check($sformatf("%s_seg%0d", tag, i), {1'b0, seg}, {1'b0, e_seg});
            check($sformatf("%s_dig%0d", tag, i), {6'd0, dig_en}, {6'd0, e_dig});
            check($sformatf("%s_ft%0d", tag, i), {7'd0, frame_tick}, {7'd0, e_ft});
            check($sformatf("%s_err%0d", tag, i), {7'd0, err}, {7'd0, exp_err});
            if (i == chg_at) begin
                bcd2 = nb2;
                bcd1 = nb1;
            end
            if (i == rst_at) begin
                rst  = 1'b0;
                bcd1 = 4'hF;
                step();
                check_reset_outputs($sformatf("%s_rst", tag));
                return;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        bcd1  = 4'd5;
        bcd2  = 4'd0;
        lzb   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_outputs($sformatf("reset%0d", i));
        end

        // Static 42: units 2 (5B), tens 4 (66), two identical frames.
        bcd2 = 4'd4;
        bcd1 = 4'd2;
        rst  = 1'b1;
        run_frame("f42a", 7'h5B, 7'h66, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);
        run_frame("f42b", 7'h5B, 7'h66, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);

        // No tearing: 0:9 then 1:0 arrives in the 3rd SHOW0 cycle.
        bcd2 = 4'd0;
        bcd1 = 4'd9;
        run_frame("tear0", 7'h6F, 7'h3F, 1'b1, 1'b0, 2, 4'd1, 4'd0, -1);
        run_frame("tear1", 7'h3F, 7'h06, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);

        // Leading-zero blank on 0:7, then 1:0 shows the tens digit.
        lzb  = 1'b1;
        bcd2 = 4'd0;
        bcd1 = 4'd7;
        run_frame("lzb07", 7'h07, 7'h00, 1'b0, 1'b0, -1, 4'd0, 4'd0, -1);
        bcd2 = 4'd1;
        bcd1 = 4'd0;
        run_frame("lzb10", 7'h3F, 7'h06, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);

        // Invalid units code C shows E and sets err; restoring 3 keeps err.
        lzb  = 1'b0;
        bcd2 = 4'd1;
        bcd1 = 4'hC;
        run_frame("badC", 7'h79, 7'h06, 1'b1, 1'b1, -1, 4'd0, 4'd0, -1);
        bcd1 = 4'd3;
        run_frame("fix3", 7'h4F, 7'h06, 1'b1, 1'b1, -1, 4'd0, 4'd0, -1);

        // Reset in the 2nd SHOW1 cycle clears err and blanks outputs.
        run_frame("rstmid", 7'h4F, 7'h06, 1'b1, 1'b1, -1, 4'd0, 4'd0, 6);
        bcd2 = 4'd5;
        bcd1 = 4'd8;
        rst  = 1'b1;
        run_frame("after", 7'h7F, 7'h6D, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);

        // Reset on the snapshot edge wins over a bad code present on that edge.
        run_frame("rstsnap", 7'h7F, 7'h6D, 1'b1, 1'b0, -1, 4'd0, 4'd0, 9);
        step();
        check_reset_outputs("rsthold");
        bcd1 = 4'd6;
        bcd2 = 4'd9;
        rst  = 1'b1;
        run_frame("fresh", 7'h7D, 7'h6F, 1'b1, 1'b0, -1, 4'd0, 4'd0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
